mult_iter: RTL and testbench

Iterative wide multiplier that computes a WIDTH x WIDTH product by time-multiplexing a single 18x18 pipelined DSP tile over 17-bit operand limbs. It supports signed and unsigned operation per request and uses a start/busy/done handshake. It sits beside the fixed 3-cycle 18x18 multiplier in the datapath and serves operations wider than one tile, trading throughput for one DSP slice.

---
 rtl/mult_iter_if.sv | 17 +
 rtl/mult_iter.sv | 99 +++++++++
 tb/tb_mult_iter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mult_iter_if.sv
// mult_iter_if: start/busy/done request bundle for the iterative multiplier.
//   start, signed_op, A, B (, acc)  requester -> multiplier
//   busy, done, O                   multiplier -> requester
//   acc exists only when MULT_ITER_ACC_EN is defined.
interface mult_iter_if #(parameter int WIDTH = 34);
   logic start, signed_op, busy, done;
   logic [WIDTH-1:0] A, B;
   logic [2*WIDTH-1:0] O;
`ifdef MULT_ITER_ACC_EN
   logic acc;
   modport master (output start, signed_op, A, B, acc, input busy, done, O);
   modport slave (input start, signed_op, A, B, acc, output busy, done, O);
`else
   modport master (output start, signed_op, A, B, input busy, done, O);
   modport slave (input start, signed_op, A, B, output busy, done, O);
`endif
endinterface

// File: rtl/mult_iter.sv
// mult_iter: WIDTH x WIDTH multiplier time-sharing one 3-stage 18x18 tile over 17-bit limbs.
//   clk, rst  clock, synchronous active-high reset
//   m         mult_iter_if.slave: start/signed_op/A/B(/acc) in, busy/done/O out
//   MULT_ITER_ACC_EN adds acc: O accumulates the new product instead of being replaced.
module mult_iter #(parameter int WIDTH = 34) (
   input logic clk,
   input logic rst,
   mult_iter_if.slave m
);
   localparam int N = (WIDTH + 16) / 17;
   localparam int MW = 17 * N;
   localparam int AW = 34 * N;
   localparam int IW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIX} state_t;
   state_t state, nxt;
   logic [MW-1:0] ma, mb;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic s, accept, last;
   logic [IW-1:0] i, j;
   logic [1:0] dc;
   logic [AW-1:0] accum;
   logic [17:0] t_a, t_b;
   logic signed [35:0] prod;
   logic [35:0] p2, p3;
   logic v1, v2, v3;
   logic [IW:0] s1, s2, s3;
   logic [2*WIDTH-1:0] val;
`ifdef MULT_ITER_ACC_EN
   logic acc_r;
`endif
   // magnitudes: -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude
   assign abs_a = (m.signed_op && m.A[WIDTH-1]) ? -m.A : m.A;
   assign abs_b = (m.signed_op && m.B[WIDTH-1]) ? -m.B : m.B;
   assign accept = m.start && state == IDLE;
   assign last = i == IW'(N - 1) && j == IW'(N - 1);
   assign prod = $signed({{18{t_a[17]}}, t_a}) * $signed({{18{t_b[17]}}, t_b});
   assign val = s ? -accum[2*WIDTH-1:0] : accum[2*WIDTH-1:0];
   assign m.busy = state != IDLE;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  nxt = m.start ? ISSUE : IDLE;
         ISSUE: nxt = last ? DRAIN : ISSUE;
         DRAIN: nxt = dc == 2'd2 ? FIX : DRAIN;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         m.O <= '0;
         m.done <= 1'b0;
         accum <= '0;
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         state <= nxt;
         m.done <= state == FIX;
         if (accept) begin
            ma <= MW'(abs_a);
            mb <= MW'(abs_b);
            s <= m.signed_op & (m.A[WIDTH-1] ^ m.B[WIDTH-1]);
            i <= '0;
            j <= '0;
            dc <= '0;
            accum <= '0;
`ifdef MULT_ITER_ACC_EN
            acc_r <= m.acc;
`endif
         end else if (v3) begin
            accum <= accum + (AW'(p3) << (17 * s3));
         end
         if (state == ISSUE) begin
            j <= j == IW'(N - 1) ? '0 : j + IW'(1);
            i <= j == IW'(N - 1) ? i + IW'(1) : i;
         end
         if (state == DRAIN) dc <= dc + 2'd1;
         // tile stage 1: zero-extended limbs plus the shift tag travel with the valid bit
         v1 <= state == ISSUE;
         t_a <= {1'b0, ma[17*i +: 17]};
         t_b <= {1'b0, mb[17*j +: 17]};
         s1 <= {1'b0, i} + {1'b0, j};
         v2 <= v1;
         p2 <= prod;
         s2 <= s1;
         v3 <= v2;
         p3 <= p2;
         s3 <= s2;
         if (state == FIX) begin
`ifdef MULT_ITER_ACC_EN
            m.O <= acc_r ? m.O + val : val;
`else
            m.O <= val;
`endif
         end
      end
   end
endmodule

// File: tb/tb_mult_iter.sv
// tb_mult_iter: directed checks of mult_iter at WIDTH=34 and WIDTH=17.
module tb_mult_iter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_err = 0;
   mult_iter_if #(.WIDTH(34)) m();
   mult_iter_if #(.WIDTH(17)) m17();
   mult_iter #(.WIDTH(34)) dut (.clk(clk), .rst(rst), .m(m));
   mult_iter #(.WIDTH(17)) dut17 (.clk(clk), .rst(rst), .m(m17));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   // called #1 after an edge; counts further edges until done, bounded
   task automatic wait_done(input int n0, output int n, output bit bz);
      n = n0;
      bz = 1'b1;
      while (!m.done && n < 20) begin
         bz &= m.busy;
         @(posedge clk);
         #1 n++;
      end
   endtask
   task automatic run(input string tag, input logic [33:0] a, input logic [33:0] b,
                      input logic sg, input logic ac, input logic [67:0] exp);
      int n;
      bit bz;
      @(negedge clk);
      m.A = a;
      m.B = b;
      m.signed_op = sg;
`ifdef MULT_ITER_ACC_EN
      m.acc = ac;
`endif
      m.start = 1'b1;
      @(posedge clk);
      #1 m.start = 1'b0;
      wait_done(0, n, bz);
      check({tag, "_lat"}, 68'(n), 68'd8);
      check({tag, "_busy"}, 68'(bz), 68'd1);
      check({tag, "_O"}, m.O, exp);
      check({tag, "_busy_at_done"}, 68'(m.busy), 68'd0);
   endtask
   initial begin
      int n, k;
      bit bz;
      m.start = 1'b0; m.signed_op = 1'b0; m.A = '0; m.B = '0;
      m17.start = 1'b0; m17.signed_op = 1'b0; m17.A = '0; m17.B = '0;
`ifdef MULT_ITER_ACC_EN
      m.acc = 1'b0;
      m17.acc = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 check("rst_O", m.O, 68'd0);
      check("rst_busy", 68'(m.busy), 68'd0);
      check("rst_done", 68'(m.done), 68'd0);
      rst = 1'b0;
      run("umax", 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 1'b0, 1'b0, 68'hF_FFFF_FFF8_0000_0001);
      run("s_m3x5", 34'h3_FFFF_FFFD, 34'd5, 1'b1, 1'b0, 68'hF_FFFF_FFFF_FFFF_FFF1);
      run("u_m3x5", 34'h3_FFFF_FFFD, 34'd5, 1'b0, 1'b0, 68'h0_0000_0013_FFFF_FFF1);
      run("s_min2", 34'h2_0000_0000, 34'h2_0000_0000, 1'b1, 1'b0, 68'h4_0000_0000_0000_0000);
      run("s_minx1", 34'h2_0000_0000, 34'd1, 1'b1, 1'b0, 68'hF_FFFF_FFFE_0000_0000);
      run("s_5xm7", 34'd5, 34'h3_FFFF_FFF9, 1'b1, 1'b0, 68'hF_FFFF_FFFF_FFFF_FFDD);
      run("limb11", 34'h0_0002_0000, 34'h0_0002_0000, 1'b0, 1'b0, 68'h4_0000_0000);
      run("u_mix", 34'h1_2345_6789, 34'd3, 1'b0, 1'b0, 68'h3_69D0_369B);
      // start held high: operands changed mid-op must be ignored, second op starts in the done cycle
      @(negedge clk);
      m.A = 34'd2; m.B = 34'd3; m.signed_op = 1'b0; m.start = 1'b1;
      @(posedge clk);
      #1 m.A = 34'd10; m.B = 34'd10;
      wait_done(0, n, bz);
      check("hold_lat1", 68'(n), 68'd8);
      check("hold_O1", m.O, 68'd6);
      @(posedge clk);
      #1 m.start = 1'b0;
      check("hold_done_pulse", 68'(m.done), 68'd0);
      check("hold_busy2", 68'(m.busy), 68'd1);
      wait_done(0, n, bz);
      check("hold_lat2", 68'(n), 68'd8);
      check("hold_O2", m.O, 68'd100);
      // start pulse mid-operation
      @(negedge clk);
      m.A = 34'd4; m.B = 34'd5; m.start = 1'b1;
      @(posedge clk);
      #1 m.start = 1'b0;
      @(negedge clk);
      m.A = 34'd9; m.B = 34'd9; m.start = 1'b1;
      @(posedge clk);
      #1 m.start = 1'b0;
      wait_done(1, n, bz);
      check("poke_lat", 68'(n), 68'd8);
      check("poke_O", m.O, 68'd20);
      @(posedge clk);
      #1 check("poke_no_2nd", 68'(m.busy), 68'd0);
      // reset mid-operation at k+4
      @(negedge clk);
      m.A = 34'd3; m.B = 34'd3; m.start = 1'b1;
      @(posedge clk);
      #1 m.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 check("abort_busy", 68'(m.busy), 68'd0);
      check("abort_done", 68'(m.done), 68'd0);
      check("abort_O", m.O, 68'd0);
      @(negedge clk) rst = 1'b0;
      k = 0;
      repeat (12) begin
         @(posedge clk);
         #1 k += int'(m.done);
      end
      check("abort_no_done", 68'(k), 68'd0);
      run("after_abort", 34'd6, 34'd7, 1'b0, 1'b0, 68'd42);
      // WIDTH=17 instance: single limb, latency 5
      @(negedge clk);
      m17.A = 17'h1FFFF; m17.B = 17'd2; m17.signed_op = 1'b0; m17.start = 1'b1;
      @(posedge clk);
      #1 m17.start = 1'b0;
      n = 0;
      while (!m17.done && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      check("w17_lat", 68'(n), 68'd5);
      check("w17_O", 68'(m17.O), 68'h3FFFE);
      @(negedge clk);
      m17.signed_op = 1'b1; m17.start = 1'b1;
      @(posedge clk);
      #1 m17.start = 1'b0;
      n = 0;
      while (!m17.done && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      check("w17_s_lat", 68'(n), 68'd5);
      check("w17_s_O", 68'(m17.O), 68'h3_FFFF_FFFE);
`ifdef MULT_ITER_ACC_EN
      run("acc_base", 34'd3, 34'd5, 1'b0, 1'b0, 68'd15);
      run("acc_add", 34'd2, 34'd3, 1'b0, 1'b1, 68'd21);
      run("acc_wrap", 34'h3_FFFF_FFFF, 34'd21, 1'b1, 1'b1, 68'd0);
      run("acc_off", 34'd7, 34'd1, 1'b0, 1'b0, 68'd7);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
